mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Consumer of the execute stage: holds the EX/MEM pipeline register, performs the data-memory
//  access for LDR/STR over a req/ready bus with wait states, and hands results to write-back.
//  Non-memory results pass through with 1-cycle latency. It stalls upstream while a bus access is pending.
// PARAMETERS
//  MEM_BASE        32'd1024  byte address mapped to bus word 0; lower addresses are illegal
//  ADDR_W          8         bus word-address width
//  TIMEOUT_CYCLES  64        BUSY cycles before abort; used only with MEM_TIMEOUT_EN
// PORTS
//  clk          in   1       single clock; all state on rising edge
//  rst          in   1       asynchronous, active-low reset
//  exValid      in   1       EX presents an instruction this cycle
//  memRead      in   1       instruction is a load
//  memWrite     in   1       instruction is a store (never both with memRead)
//  wbEnIn       in   1       instruction writes a register
//  destIn       in   4       destination register
//  aluResult    in   32      ALU result / byte address
//  storeVal     in   32      store data (Rd value)
//  stall        out  1       hold EX/ID/IF; combinational
//  busReq       out  1       bus request, registered
//  busWe        out  1       1 = write
//  busAddr      out  ADDR_W  word address
//  busWdata     out  32      write data
//  busRdata     in   32      read data, valid when busReady=1
//  busReady     in   1       access completes this cycle
//  wbValid      out  1       WB outputs valid this cycle
//  wbEn         out  1       register write enable to WB
//  wbDest       out  4       destination to WB
//  wbData       out  32      load data or ALU result
//  memError     out  1       1-cycle pulse: illegal address (or timeout)
// BEHAVIOUR
//  Reset (rst=0): state IDLE; busReq, busWe, wbValid, wbEn, memError = 0; busAddr, busWdata,
//   wbDest, wbData = 0. Takes effect immediately, also mid-access (busReq drops at once).
//  States: IDLE, BUSY. stall = (state==BUSY) && !busReady. The EX input is sampled only when stall=0.
//  IDLE, exValid, no mem op: next cycle wbValid=1, wbData=aluResult, wbEn=wbEnIn, wbDest=destIn.
//  IDLE, exValid, mem op, legal address: capture the access, go BUSY. Next cycle busReq=1,
//   busWe=memWrite, busAddr=(aluResult-MEM_BASE)>>2 truncated to ADDR_W, busWdata=storeVal.
//  Legal address: aluResult>=MEM_BASE, aluResult[1:0]==0, word index < 2**ADDR_W. Otherwise
//   there is no bus access; next cycle memError=1, wbValid=1, wbEn=0.
//  BUSY: bus outputs are held stable until busReady=1. In the busReady cycle: busReq drops next
//   cycle; next cycle wbValid=1, wbData=busRdata (load, wbEn=wbEnIn) or wbEn=0 (store);
//   the same edge accepts the next EX instruction (back-to-back, no bubble).
//  Zero-wait bus (ready in the first req cycle): load result reaches WB 2 cycles after accept.
//  exValid=0 with stall=0: wbValid=0 next cycle. wbValid is always a single-cycle pulse per instruction.
//  busReady while IDLE: ignored.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: a BUSY cycle counter resets on entry to BUSY. If it reaches
//   TIMEOUT_CYCLES without busReady: busReq drops, state returns to IDLE, memError pulses,
//   wbValid=1 with wbEn=0, and stall releases. A late busReady is then ignored.
//  MEM_TIMEOUT_EN undefined: the block waits in BUSY indefinitely; memError reports illegal addresses only.
// STRUCTURE
//  Shared package/header: state encoding (IDLE/BUSY), MEM_BASE default, register-index width (4).
//  Optional sub-module access_watchdog (counter + expiry flag), instantiated only under MEM_TIMEOUT_EN.
// TESTING
//  ADD result 32'h55, wbEnIn=1, dest=3 -> next cycle wbValid=1, wbData=32'h55, wbDest=3, busReq=0.
//  LDR addr 1032, ready after 3 wait cycles, rdata=32'hDEADBEEF -> busAddr=2, stall=1 for 3 cycles,
//   then wbData=32'hDEADBEEF, wbEn=1.
//  STR addr 1024, storeVal=7, ready immediately, followed by ADD -> busWe=1, busAddr=0,
//   busWdata=7; store wbEn=0; ADD is accepted with no bubble.
//  LDR addr 1026 and LDR addr 1000 -> no busReq; memError pulses; wbValid=1, wbEn=0 for each.
//  rst low during BUSY -> busReq=0 and stall=0 immediately; after release, state IDLE and outputs 0.
//  MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted -> abort after 4 BUSY cycles;
//   memError=1, stall=0.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
// Optional feature macro used by the stage: MEM_TIMEOUT_EN (bus access watchdog).
package mem_access_stage_pkg;

  // Access state: IDLE accepts from EX, BUSY owns the data bus
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [31:0] MEM_BASE_DEFAULT = 32'd1024;
  localparam int          REG_W            = 4;

  // One write-back result, either ready to emit or parked for one cycle
  typedef struct packed {
    logic             valid;
    logic             en;
    logic             err;
    logic [REG_W-1:0] dest;
    logic [31:0]      data;
  } wb_result_t;

  // Address must lie at or above the base, be word aligned and index inside the bus window
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          aw);
    logic [31:0] offset;
    offset = addr - base;
    return (addr >= base) && (addr[1:0] == 2'b00) && ((offset >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/access_watchdog.sv
// Bus access watchdog: counts BUSY cycles without busReady and flags expiry.
// Only instantiated by mem_access_stage when MEM_TIMEOUT_EN is defined.
module access_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic ready,
  input  logic start,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] count;

  // Expiry happens in the LIMIT-th waiting cycle so the stage leaves BUSY after exactly LIMIT cycles
  assign expired = busy && !ready && (count == CNT_W'(LIMIT - 1));

  // Restart on every new access (including back-to-back ones) and count only waiting cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (start || !busy) begin
      count <= '0;
    end else if (!ready && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM register plus data-memory access over a req/ready bus, feeding write-back.
// Optional feature: define MEM_TIMEOUT_EN to abort bus accesses after TIMEOUT_CYCLES busy cycles.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter logic [31:0] MEM_BASE       = MEM_BASE_DEFAULT,
  parameter int          ADDR_W         = 8,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exValid,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              wbEnIn,
  input  logic [REG_W-1:0]  destIn,
  input  logic [31:0]       aluResult,
  input  logic [31:0]       storeVal,
  output logic              stall,
  output logic              busReq,
  output logic              busWe,
  output logic [ADDR_W-1:0] busAddr,
  output logic [31:0]       busWdata,
  input  logic [31:0]       busRdata,
  input  logic              busReady,
  output logic              wbValid,
  output logic              wbEn,
  output logic [REG_W-1:0]  wbDest,
  output logic [31:0]       wbData,
  output logic              memError
);

  state_t             state;
  logic               pend_load;
  logic               pend_wben;
  logic [REG_W-1:0]   pend_dest;
  logic [31:0]        pend_alu;
  wb_result_t         skid;
  wb_result_t         imm_res;
  wb_result_t         cpl_res;
  wb_result_t         emit;
  wb_result_t         skid_next;
  logic               accept;
  logic               is_mem;
  logic               legal;
  logic               new_access;
  logic               done;
  logic               expire;
  logic               busy;
  logic [ADDR_W-1:0]  word_addr;

  assign busy       = (state == BUSY);
  assign stall      = busy && !busReady;
  assign accept     = exValid && !stall;
  assign is_mem     = memRead | memWrite;
  assign legal      = addr_legal(aluResult, MEM_BASE, ADDR_W);
  assign new_access = accept && is_mem && legal;
  assign done       = busy && (busReady || expire);
  assign word_addr  = ADDR_W'((aluResult - MEM_BASE) >> 2);

`ifdef MEM_TIMEOUT_EN
  access_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .busy   (busy),
    .ready  (busReady),
    .start  (new_access),
    .expired(expire)
  );
`else
  logic unused_timeout_cfg;
  assign expire             = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Build the immediate and completion results and pick which one goes to WB this edge.
  // A completion and an instruction accepted on the same edge would collide, so the newer
  // one is parked in a one-entry skid and emitted on the following edge.
  always_comb begin
    imm_res       = '0;
    imm_res.valid = accept && !(is_mem && legal);
    imm_res.en    = !is_mem && wbEnIn;
    imm_res.err   = is_mem;
    imm_res.dest  = destIn;
    imm_res.data  = aluResult;

    cpl_res       = '0;
    cpl_res.valid = done;
    cpl_res.en    = busReady && pend_load && pend_wben;
    cpl_res.err   = !busReady;
    cpl_res.dest  = pend_dest;
    cpl_res.data  = (busReady && pend_load) ? busRdata : pend_alu;

    emit      = skid.valid ? skid : cpl_res;
    skid_next = '0;
    if (emit.valid) begin
      skid_next = imm_res;
    end else begin
      emit = imm_res;
    end
  end

  // Access state machine with registered bus and write-back outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busReq    <= 1'b0;
      busWe     <= 1'b0;
      busAddr   <= '0;
      busWdata  <= '0;
      pend_load <= 1'b0;
      pend_wben <= 1'b0;
      pend_dest <= '0;
      pend_alu  <= '0;
      skid      <= '0;
      wbValid   <= 1'b0;
      wbEn      <= 1'b0;
      wbDest    <= '0;
      wbData    <= '0;
      memError  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (new_access) begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (done && !new_access) begin
            state  <= IDLE;
            busReq <= 1'b0;
            busWe  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (new_access) begin
        busReq    <= 1'b1;
        busWe     <= memWrite;
        busAddr   <= word_addr;
        busWdata  <= storeVal;
        pend_load <= memRead;
        pend_wben <= wbEnIn;
        pend_dest <= destIn;
        pend_alu  <= aluResult;
      end

      skid     <= skid_next;
      wbValid  <= emit.valid;
      wbEn     <= emit.valid && emit.en;
      memError <= emit.valid && emit.err;
      if (emit.valid) begin
        wbDest <= emit.dest;
        wbData <= emit.data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
// The timeout scenario is exercised only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        exValid;
  logic        memRead;
  logic        memWrite;
  logic        wbEnIn;
  logic [3:0]  destIn;
  logic [31:0] aluResult;
  logic [31:0] storeVal;
  logic        stall;
  logic        busReq;
  logic        busWe;
  logic [7:0]  busAddr;
  logic [31:0] busWdata;
  logic [31:0] busRdata;
  logic        busReady;
  logic        wbValid;
  logic        wbEn;
  logic [3:0]  wbDest;
  logic [31:0] wbData;
  logic        memError;

  int vectorCount = 0;
  int failCount   = 0;

  mem_access_stage #(
    .MEM_BASE      (32'd1024),
    .ADDR_W        (8),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .exValid  (exValid),
    .memRead  (memRead),
    .memWrite (memWrite),
    .wbEnIn   (wbEnIn),
    .destIn   (destIn),
    .aluResult(aluResult),
    .storeVal (storeVal),
    .stall    (stall),
    .busReq   (busReq),
    .busWe    (busWe),
    .busAddr  (busAddr),
    .busWdata (busWdata),
    .busRdata (busRdata),
    .busReady (busReady),
    .wbValid  (wbValid),
    .wbEn     (wbEn),
    .wbDest   (wbDest),
    .wbData   (wbData),
    .memError (memError)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one EX-stage instruction (ev=0 means no instruction)
  task automatic applyStimulus(input logic ev, input logic rd, input logic wr,
                               input logic wen, input logic [3:0] dest,
                               input logic [31:0] alu, input logic [31:0] sv);
    exValid   = ev;
    memRead   = rd;
    memWrite  = wr;
    wbEnIn    = wen;
    destIn    = dest;
    aluResult = alu;
    storeVal  = sv;
  endtask

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
    end
  endtask

  initial begin
    int waits;
    clk      = 1'b0;
    rst      = 1'b0;
    busRdata = '0;
    busReady = 1'b0;
    applyStimulus(0, 0, 0, 0, 4'd0, 32'd0, 32'd0);

    tick();
    tick();
    checkOutput("rstBusReq",   busReq,   0);
    checkOutput("rstBusWe",    busWe,    0);
    checkOutput("rstWbValid",  wbValid,  0);
    checkOutput("rstMemError", memError, 0);
    checkOutput("rstBusAddr",  busAddr,  0);
    checkOutput("rstWbData",   wbData,   0);
    checkOutput("rstStall",    stall,    0);
    rst = 1'b1;
    tick();

    $display("[TB] busReady while idle");
    busReady = 1'b1;
    tick();
    busReady = 1'b0;
    checkOutput("idleRdyValid",  wbValid, 0);
    checkOutput("idleRdyBusReq", busReq,  0);

    $display("[TB] ALU pass-through");
    applyStimulus(1, 0, 0, 1, 4'd3, 32'h55, 32'd0);
    checkOutput("addStall", stall, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    checkOutput("addWbValid", wbValid, 1);
    checkOutput("addWbData",  wbData,  32'h55);
    checkOutput("addWbDest",  wbDest,  3);
    checkOutput("addWbEn",    wbEn,    1);
    checkOutput("addBusReq",  busReq,  0);
    tick();
    checkOutput("addPulse", wbValid, 0);

    $display("[TB] load with three wait states");
    applyStimulus(1, 1, 0, 1, 4'd5, 32'd1032, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    checkOutput("ldrBusReq",  busReq,  1);
    checkOutput("ldrBusWe",   busWe,   0);
    checkOutput("ldrBusAddr", busAddr, 2);
    waits = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall) waits++;
      tick();
    end
    checkOutput("ldrStallCycles", waits, 3);
    checkOutput("ldrHeldAddr", busAddr, 2);
    busReady = 1'b1;
    busRdata = 32'hDEADBEEF;
    #1;
    checkOutput("ldrReadyStall", stall, 0);
    tick();
    busReady = 1'b0;
    busRdata = '0;
    checkOutput("ldrWbValid", wbValid, 1);
    checkOutput("ldrWbData",  wbData,  32'hDEADBEEF);
    checkOutput("ldrWbEn",    wbEn,    1);
    checkOutput("ldrWbDest",  wbDest,  5);
    checkOutput("ldrReqDrop", busReq,  0);
    tick();

    $display("[TB] zero-wait store followed by ALU op");
    applyStimulus(1, 0, 1, 0, 4'd1, 32'd1024, 32'd7);
    tick();
    checkOutput("strBusReq",   busReq,   1);
    checkOutput("strBusWe",    busWe,    1);
    checkOutput("strBusAddr",  busAddr,  0);
    checkOutput("strBusWdata", busWdata, 7);
    busReady = 1'b1;
    applyStimulus(1, 0, 0, 1, 4'd2, 32'h99, 32'd0);
    #1;
    checkOutput("strNoBubble", stall, 0);
    tick();
    busReady = 1'b0;
    applyStimulus(0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    checkOutput("strWbValid", wbValid, 1);
    checkOutput("strWbEn",    wbEn,    0);
    checkOutput("strReqDrop", busReq,  0);
    tick();
    checkOutput("addAfterStrValid", wbValid, 1);
    checkOutput("addAfterStrData",  wbData,  32'h99);
    checkOutput("addAfterStrEn",    wbEn,    1);
    checkOutput("addAfterStrDest",  wbDest,  2);
    tick();
    checkOutput("addAfterStrPulse", wbValid, 0);

    $display("[TB] illegal addresses");
    applyStimulus(1, 1, 0, 1, 4'd4, 32'd1026, 32'd0);
    tick();
    applyStimulus(1, 1, 0, 1, 4'd6, 32'd1000, 32'd0);
    checkOutput("misalignBusReq", busReq,   0);
    checkOutput("misalignErr",    memError, 1);
    checkOutput("misalignValid",  wbValid,  1);
    checkOutput("misalignWbEn",   wbEn,     0);
    tick();
    applyStimulus(0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    checkOutput("lowAddrBusReq", busReq,   0);
    checkOutput("lowAddrErr",    memError, 1);
    checkOutput("lowAddrValid",  wbValid,  1);
    checkOutput("lowAddrWbEn",   wbEn,     0);
    tick();
    checkOutput("errPulse", memError, 0);

    $display("[TB] window edges");
    applyStimulus(1, 1, 0, 1, 4'd7, 32'd2044, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    checkOutput("topWordReq",  busReq,  1);
    checkOutput("topWordAddr", busAddr, 8'hFF);
    busReady = 1'b1;
    busRdata = 32'h12345678;
    tick();
    busReady = 1'b0;
    busRdata = '0;
    checkOutput("topWordData", wbData, 32'h12345678);
    applyStimulus(1, 1, 0, 1, 4'd7, 32'd2048, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    checkOutput("pastTopBusReq", busReq,   0);
    checkOutput("pastTopErr",    memError, 1);
    tick();

    $display("[TB] reset during access");
    applyStimulus(1, 1, 0, 1, 4'd8, 32'd1040, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    checkOutput("midBusyReq",   busReq, 1);
    checkOutput("midBusyStall", stall,  1);
    rst = 1'b0;
    #1;
    checkOutput("midRstReq",   busReq, 0);
    checkOutput("midRstStall", stall,  0);
    tick();
    tick();
    rst = 1'b1;
    checkOutput("postRstAddr",   busAddr,  0);
    checkOutput("postRstWdata",  busWdata, 0);
    checkOutput("postRstWbData", wbData,   0);
    checkOutput("postRstWbDest", wbDest,   0);
    checkOutput("postRstValid",  wbValid,  0);
    tick();
    checkOutput("postRstIdleReq", busReq, 0);
    applyStimulus(1, 0, 0, 1, 4'd9, 32'h1234, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    checkOutput("postRstAddData", wbData, 32'h1234);
    tick();

`ifdef MEM_TIMEOUT_EN
    $display("[TB] bus timeout");
    applyStimulus(1, 1, 0, 1, 4'd10, 32'd1028, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    waits = 0;
    while (stall && waits < 10) begin
      waits++;
      tick();
    end
    checkOutput("toBusyCycles", waits,    4);
    checkOutput("toStall",      stall,    0);
    checkOutput("toBusReq",     busReq,   0);
    checkOutput("toMemError",   memError, 1);
    checkOutput("toWbValid",    wbValid,  1);
    checkOutput("toWbEn",       wbEn,     0);
    busReady = 1'b1;
    tick();
    busReady = 1'b0;
    checkOutput("toLateReady", wbValid, 0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
